iquv_frame_tx: RTL and testbench

IQUV_FRAME_TX -- requirements
Module: iquv_frame_tx

---
 rtl/iquv_pkg.sv | 27 ++
 rtl/iquv_frame_ram.sv | 28 ++
 rtl/iquv_frame_tx.sv | 190 +++++++++++++++++++
 tb/tb_iquv_frame_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iquv_pkg.sv
// Shared definitions for the IQUV frame transmitter: FSM state encoding,
// default header tag, the per-bin Stokes payload and word-index sizing.
package iquv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_SEND_HDR  = 2'd2,
        ST_SEND_DATA = 2'd3
    } state_e;

    localparam logic [15:0] HDR_TAG_DEF = 16'hA5A5;

    // One buffered bin: I in the top word, V in the bottom word.
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] q;
        logic [31:0] u;
        logic [31:0] v;
    } stokes_t;

    // Width of a counter that must reach 4*fft_point inclusive (one past the last word).
    function automatic int unsigned word_idx_w(input int unsigned fft_point);
        return $clog2(4 * fft_point) + 1;
    endfunction

endpackage

// File: rtl/iquv_frame_ram.sv
// Simple dual-port frame buffer: one 128-bit Stokes bin per address,
// synchronous write, registered (1-cycle) read.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module iquv_frame_ram
    import iquv_pkg::*;
#(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  stokes_t           wdata,
    input  logic [ADDR_W-1:0] raddr,
    output stokes_t           rdata
);

    stokes_t mem [DEPTH];

    // Storage is not reset; contents are always rewritten before being sent.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/iquv_frame_tx.sv
// Captures one FFT frame of accumulated Stokes bins into a buffer and
// streams it out as a header word followed by I,Q,U,V words per bin on a
// valid/ready interface. Frames arriving while busy are counted as drops.
// Ports: clk, rst (async, active-low); en_sync_in/cnt_sync_in/para_in_* bin
// input; tx_data/tx_valid/tx_ready/tx_sof/tx_eof output stream;
// drop_cnt saturating drop counter; busy when not idle.
module iquv_frame_tx
    import iquv_pkg::*;
#(
    parameter int unsigned BITWIDTH  = 7,
    parameter int unsigned FFT_POINT = 512,
    parameter logic [15:0] HDR_TAG   = HDR_TAG_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_sync_in,
    input  logic [BITWIDTH+1:0] cnt_sync_in,
    input  logic [31:0]         para_in_I0,
    input  logic [31:0]         para_in_Q0,
    input  logic [31:0]         para_in_U0,
    input  logic [31:0]         para_in_V0,
    output logic [31:0]         tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                tx_sof,
    output logic                tx_eof,
    output logic [15:0]         drop_cnt,
    output logic                busy
);

    localparam int unsigned CNT_W  = BITWIDTH + 2;
    localparam int unsigned RAM_AW = $clog2(FFT_POINT);
    localparam int unsigned WIDX_W = word_idx_w(FFT_POINT);

    localparam logic [CNT_W-1:0]  LAST_BIN  = CNT_W'(FFT_POINT - 1);
    localparam logic [CNT_W:0]    N_BINS    = (CNT_W + 1)'(FFT_POINT);
    localparam logic [WIDX_W-1:0] N_WORDS   = WIDX_W'(4 * FFT_POINT);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(4 * FFT_POINT - 1);

    state_e              state, state_d;
    logic                rst_meta, rst_sync;
    logic [WIDX_W-1:0]   widx, widx_d;
    logic [15:0]         frame_seq, frame_seq_d;
    logic [15:0]         drop_cnt_d;
    logic [31:0]         tx_data_d;
    logic                tx_valid_d, tx_sof_d, tx_eof_d;
    logic                ram_we_c;
    logic [WIDX_W-1:0]   rd_word_c;
    logic [RAM_AW-1:0]   ram_waddr_c, ram_raddr_c;
    stokes_t             ram_wdata_c, ram_rdata;
    logic [31:0]         lane_word_c;
    logic                bin0_c, xfer_c, drop_c, in_range_c;

    // Reset asserts asynchronously, releases two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign ram_wdata_c = '{i: para_in_I0, q: para_in_Q0, u: para_in_U0, v: para_in_V0};
    assign ram_waddr_c = RAM_AW'(cnt_sync_in);
    // Read address is one word ahead when a word is loaded this cycle, so the
    // bin needed by the next load is already in rdata (hides the read latency).
    assign ram_raddr_c = RAM_AW'(rd_word_c >> 2);

    iquv_frame_ram #(
        .DEPTH (FFT_POINT),
        .ADDR_W(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_c),
        .waddr(ram_waddr_c),
        .wdata(ram_wdata_c),
        .raddr(ram_raddr_c),
        .rdata(ram_rdata)
    );

    // Pick the Stokes component for the next data word.
    always_comb begin
        lane_word_c = ram_rdata.i;
        unique case (widx[1:0])
            2'd0: lane_word_c = ram_rdata.i;
            2'd1: lane_word_c = ram_rdata.q;
            2'd2: lane_word_c = ram_rdata.u;
            2'd3: lane_word_c = ram_rdata.v;
        endcase
    end

    // Next-state, buffer write and output-register next values.
    always_comb begin
        state_d     = state;
        widx_d      = widx;
        frame_seq_d = frame_seq;
        drop_cnt_d  = drop_cnt;
        tx_data_d   = tx_data;
        tx_valid_d  = tx_valid;
        tx_sof_d    = tx_sof;
        tx_eof_d    = tx_eof;
        ram_we_c    = 1'b0;
        rd_word_c   = widx;
        drop_c      = 1'b0;
        bin0_c      = en_sync_in && (cnt_sync_in == '0);
        xfer_c      = tx_valid && tx_ready;
        in_range_c  = ({1'b0, cnt_sync_in} < N_BINS);

        if (xfer_c) begin
            tx_valid_d = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                widx_d = '0;
                if (bin0_c) begin
                    ram_we_c = 1'b1;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                widx_d = '0;
                if (en_sync_in && in_range_c) begin
                    ram_we_c = 1'b1;
                end
                // A new bin 0 abandons the partial frame and restarts capture.
                if (bin0_c) begin
                    drop_c = 1'b1;
                end else if (en_sync_in && (cnt_sync_in == LAST_BIN)) begin
                    state_d = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: begin
                drop_c     = bin0_c;
                tx_valid_d = 1'b1;
                tx_data_d  = {HDR_TAG, frame_seq};
                tx_sof_d   = 1'b1;
                tx_eof_d   = 1'b0;
                state_d    = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                drop_c = bin0_c;
                if ((!tx_valid || tx_ready) && (widx != N_WORDS)) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = lane_word_c;
                    tx_sof_d   = 1'b0;
                    tx_eof_d   = (widx == LAST_WORD);
                    widx_d     = widx + WIDX_W'(1);
                    rd_word_c  = widx + WIDX_W'(1);
                end
                if (xfer_c && tx_eof) begin
                    state_d     = ST_IDLE;
                    frame_seq_d = frame_seq + 16'd1;
                end
            end
        endcase

        if (drop_c && (drop_cnt != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt + 16'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= ST_IDLE;
            widx      <= '0;
            frame_seq <= '0;
            drop_cnt  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_sof    <= 1'b0;
            tx_eof    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            widx      <= widx_d;
            frame_seq <= frame_seq_d;
            drop_cnt  <= drop_cnt_d;
            tx_data   <= tx_data_d;
            tx_valid  <= tx_valid_d;
            tx_sof    <= tx_sof_d;
            tx_eof    <= tx_eof_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_iquv_frame_tx.sv
// Directed self-checking bench for iquv_frame_tx: full frames with free and
// stalled sink, mid-frame restart, overlapping frames, drop at end of frame,
// reset mid-frame, and headless input while idle.
module tb_iquv_frame_tx;

    localparam int unsigned BW  = 7;
    localparam int unsigned FFT = 512;
    localparam int          NW  = 4 * FFT + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_sync_in;
    logic [BW+1:0] cnt_sync_in;
    logic [31:0]   para_in_I0, para_in_Q0, para_in_U0, para_in_V0;
    logic [31:0]   tx_data;
    logic          tx_valid, tx_ready, tx_sof, tx_eof;
    logic [15:0]   drop_cnt;
    logic          busy;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [33:0]   got[$];
    int            bubbles, unstable, timed_out;
    int            vseen, bseen;

    iquv_frame_tx #(
        .BITWIDTH (BW),
        .FFT_POINT(FFT),
        .HDR_TAG  (16'hA5A5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_sync_in (en_sync_in),
        .cnt_sync_in(cnt_sync_in),
        .para_in_I0 (para_in_I0),
        .para_in_Q0 (para_in_Q0),
        .para_in_U0 (para_in_U0),
        .para_in_V0 (para_in_V0),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // Expected {sof, eof, data} for word n of a frame.
    function automatic logic [33:0] exp_word(input int n, input logic [15:0] seq, input int base);
        int d;
        int val;
        if (n == 0) return {2'b10, 16'hA5A5, seq};
        d   = n - 1;
        val = d / 4 + 1000 * (d % 4) + base;
        return {1'b0, (n == NW - 1), 32'(val)};
    endfunction

    // Present bins first..last on consecutive cycles; call and return at a negedge.
    task automatic drive_bins(input int first, input int last, input int base);
        for (int k = first; k <= last; k++) begin
            en_sync_in  = 1'b1;
            cnt_sync_in = (BW + 2)'(k);
            para_in_I0  = 32'(k + base);
            para_in_Q0  = 32'(k + 1000 + base);
            para_in_U0  = 32'(k + 2000 + base);
            para_in_V0  = 32'(k + 3000 + base);
            @(negedge clk);
        end
        en_sync_in = 1'b0;
    endtask

    // Sink: accept words until eof (or stop_at words), optional ready toggling,
    // optional bin-0 injection in the same cycle as the eof transfer.
    task automatic collect(input bit toggle, input int stop_at, input bit poke_eof);
        logic [33:0] held;
        bit          stalled;
        bit          started;
        bit          rdy;
        int          cyc;
        held = '0; stalled = 1'b0; started = 1'b0; cyc = 0;
        got.delete();
        bubbles = 0; unstable = 0; timed_out = 0;
        forever begin
            if (cyc >= 6000) begin
                timed_out = 1;
                break;
            end
            if (stalled && (!tx_valid || ({tx_sof, tx_eof, tx_data} !== held))) unstable++;
            rdy      = toggle ? ((cyc % 2) == 0) : 1'b1;
            tx_ready = rdy;
            if (tx_valid) started = 1'b1;
            else if (started && rdy) bubbles++;
            stalled = tx_valid && !rdy;
            held    = {tx_sof, tx_eof, tx_data};
            if (tx_valid && rdy) begin
                got.push_back(held);
                if (tx_eof) begin
                    if (poke_eof) begin
                        en_sync_in  = 1'b1;
                        cnt_sync_in = '0;
                    end
                    break;
                end
                if (got.size() == stop_at) break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] seq, input int base);
        int mm;
        mm = 0;
        check({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check({tag, "_words"}, 32'(got.size()), 32'(NW));
        for (int n = 0; n < got.size(); n++) begin
            if (got[n] !== exp_word(n, seq, base)) mm++;
        end
        check({tag, "_word_errs"}, 32'(mm), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en_sync_in = 1'b0; cnt_sync_in = '0; tx_ready = 1'b1;
        para_in_I0 = '0; para_in_Q0 = '0; para_in_U0 = '0; para_in_V0 = '0;

        // Reset state
        #3 rst = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_sof",   32'(tx_sof),   32'd0);
        check("rst_tx_eof",   32'(tx_eof),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_tx_data",  tx_data,       32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Full frame, sink always ready
        drive_bins(0, FFT - 1, 0);
        check("t1_hdr_state_valid", 32'(tx_valid), 32'd0);
        check("t1_hdr_state_busy",  32'(busy),     32'd1);
        @(negedge clk);
        check("t1_first_valid", 32'(tx_valid), 32'd1);
        check("t1_first_sof",   32'(tx_sof),   32'd1);
        collect(1'b0, 0, 1'b0);
        check_frame("t1", 16'd0, 0);
        check("t1_header", got[0][31:0], 32'hA5A50000);
        check("t1_hdr_sof", 32'(got[0][33]), 32'd1);
        check("t1_word4", got[5][31:0], 32'd1);
        check("t1_last", got[NW-1][31:0], 32'd3511);
        check("t1_last_eof", 32'(got[NW-1][32]), 32'd1);
        check("t1_bubbles", 32'(bubbles), 32'd0);
        @(negedge clk);
        check("t1_idle_busy",  32'(busy),     32'd0);
        check("t1_idle_valid", 32'(tx_valid), 32'd0);

        // Same frame, sink ready toggling; bin 0 arrives with the eof transfer
        drive_bins(0, FFT - 1, 0);
        collect(1'b1, 0, 1'b1);
        check_frame("t2", 16'd1, 0);
        check("t2_stable", 32'(unstable), 32'd0);
        @(negedge clk);
        en_sync_in = 1'b0;
        check("t2_eof_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t2_eof_drop_idle", 32'(busy), 32'd0);
        tx_ready = 1'b1;

        // Partial frame restarted by a new bin 0
        do_reset();
        drive_bins(0, 99, 50000);
        drive_bins(0, FFT - 1, 0);
        collect(1'b0, 0, 1'b0);
        check_frame("t3", 16'd0, 0);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        @(negedge clk);

        // Second frame during SEND_DATA is dropped; third frame after idle
        do_reset();
        fork
            begin
                drive_bins(0, FFT - 1, 0);
                repeat (20) @(negedge clk);
                drive_bins(0, FFT - 1, 7000);
            end
            collect(1'b0, 0, 1'b0);
        join
        check_frame("t4a", 16'd0, 0);
        @(negedge clk);
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t4_idle_busy", 32'(busy), 32'd0);
        drive_bins(0, FFT - 1, 300);
        collect(1'b0, 0, 1'b0);
        check_frame("t4c", 16'd1, 300);
        check("t4c_drop_cnt", 32'(drop_cnt), 32'd1);
        @(negedge clk);

        // Reset mid-frame at output word 700
        drive_bins(0, FFT - 1, 0);
        collect(1'b0, 700, 1'b0);
        check("t5_reached_700", 32'(got.size()), 32'd700);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(tx_valid), 32'd0);
        check("t5_rst_busy",  32'(busy),     32'd0);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vseen = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx_valid) vseen++;
        end
        check("t5_no_valid_after_rst", 32'(vseen), 32'd0);
        drive_bins(0, FFT - 1, 100);
        collect(1'b0, 0, 1'b0);
        check_frame("t5", 16'd0, 100);
        @(negedge clk);

        // Headless bins while idle are ignored
        drive_bins(5, FFT - 1, 0);
        vseen = 0;
        bseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_valid) vseen++;
            if (busy) bseen++;
        end
        check("t6_no_valid", 32'(vseen), 32'd0);
        check("t6_no_busy",  32'(bseen), 32'd0);
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
